// File: rtl/top_decryption_if.sv
// Control and data bundle for the AES-128 inverse cipher.
// The master drives launch/abort and operands; the slave returns the plaintext.
interface top_decryption_if;
   logic         start;
   logic         restart;
   logic [127:0] key_in;
   logic [127:0] cipher_text;
   logic [127:0] plain_text;
   logic         done;

   modport master (
      output start, restart, key_in, cipher_text,
      input  plain_text, done
   );

   modport slave (
      input  start, restart, key_in, cipher_text,
      output plain_text, done
   );
endinterface

// File: rtl/top_decryption.sv
// Iterative AES-128 inverse cipher, one round per clock.
// Round keys are expanded into a local store before the inverse rounds run.
module top_decryption (
   input  logic             clk,
   input  logic             reset,
   top_decryption_if.slave  bus
);

   typedef enum logic [2:0] {
      IDLE, KEYEXP, INIT, ROUND, FINAL, DONE
   } state_t;

   state_t       st;
   logic [127:0] rk [0:10];
   logic [127:0] blk;
   logic [127:0] result;
   logic         done_flag;
   logic [3:0]   kcnt;
   logic [3:0]   rcnt;

   logic         launch;
   logic         kload;
   logic [127:0] key_prev;
   logic [127:0] key_next;
   logic [127:0] rk_round;
   logic [127:0] isr;
   logic [127:0] isb;
   logic [127:0] ark;
   logic [127:0] imc;
   logic [127:0] final_out;

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(
      input logic [7:0] a,
      input logic [7:0] b
   );
      logic [7:0] p;
      logic [7:0] x;
      p = '0;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // Multiplicative inverse as x^254 via an addition chain; 0 maps to 0.
   function automatic logic [7:0] gf_inv(input logic [7:0] x);
      logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
      x2   = gf_mul(x, x);
      x3   = gf_mul(x2, x);
      x6   = gf_mul(x3, x3);
      x12  = gf_mul(x6, x6);
      x15  = gf_mul(x12, x3);
      x30  = gf_mul(x15, x15);
      x60  = gf_mul(x30, x30);
      x120 = gf_mul(x60, x60);
      x240 = gf_mul(x120, x120);
      x252 = gf_mul(x240, x12);
      return gf_mul(x252, x2);
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] b;
      b = gf_inv(a);
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]}
               ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] s);
      logic [7:0] b;
      b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]}
        ^ {s[1:0], s[7:2]} ^ 8'h05;
      return gf_inv(b);
   endfunction

   function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
      logic [7:0] a [4];
      logic [7:0] m9 [4];
      logic [7:0] mb [4];
      logic [7:0] md [4];
      logic [7:0] me [4];
      logic [7:0] x2, x4, x8;
      for (int i = 0; i < 4; i++) begin
         a[i]  = c[31-8*i -: 8];
         x2    = xtime(a[i]);
         x4    = xtime(x2);
         x8    = xtime(x4);
         m9[i] = x8 ^ a[i];
         mb[i] = x8 ^ x2 ^ a[i];
         md[i] = x8 ^ x4 ^ a[i];
         me[i] = x8 ^ x4 ^ x2;
      end
      return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
              m9[0] ^ me[1] ^ mb[2] ^ md[3],
              md[0] ^ m9[1] ^ me[2] ^ mb[3],
              mb[0] ^ md[1] ^ m9[2] ^ me[3]};
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] n);
      logic [7:0] v;
      v = 8'h00;
      unique case (n)
         4'd1:    v = 8'h01;
         4'd2:    v = 8'h02;
         4'd3:    v = 8'h04;
         4'd4:    v = 8'h08;
         4'd5:    v = 8'h10;
         4'd6:    v = 8'h20;
         4'd7:    v = 8'h40;
         4'd8:    v = 8'h80;
         4'd9:    v = 8'h1b;
         4'd10:   v = 8'h36;
         default: v = 8'h00;
      endcase
      return v;
   endfunction

   assign launch = !bus.restart && bus.start
                && (st == IDLE || st == DONE);
   assign kload  = !bus.restart && (st == KEYEXP);

   // Key schedule step: RotWord, SubWord and Rcon on the last word.
   always_comb begin
      logic [31:0] w3;
      logic [31:0] t;
      key_prev = rk[kcnt - 4'd1];
      w3 = key_prev[31:0];
      t  = {sbox(w3[23:16]), sbox(w3[15:8]),
            sbox(w3[7:0]),   sbox(w3[31:24])};
      t  = t ^ {rcon(kcnt), 24'h0};
      key_next[127:96] = key_prev[127:96] ^ t;
      key_next[95:64]  = key_prev[95:64]  ^ key_next[127:96];
      key_next[63:32]  = key_prev[63:32]  ^ key_next[95:64];
      key_next[31:0]   = key_prev[31:0]   ^ key_next[63:32];
   end

   // Row r is rotated right by r columns.
   always_comb begin
      isr = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            isr[127-8*(4*c+r) -: 8] =
               blk[127-8*(4*((c-r+4)%4)+r) -: 8];
         end
      end
   end

   always_comb begin
      isb = '0;
      for (int i = 0; i < 16; i++) begin
         isb[127-8*i -: 8] = inv_sbox(isr[127-8*i -: 8]);
      end
   end

   assign rk_round  = rk[rcnt];
   assign ark       = isb ^ rk_round;
   assign final_out = isb ^ rk[0];

   always_comb begin
      imc = '0;
      for (int c = 0; c < 4; c++) begin
         imc[127-32*c -: 32] = inv_mix_col(ark[127-32*c -: 32]);
      end
   end

   // Key store is not reset; it is always rewritten before use.
   always_ff @(posedge clk) begin
      if (launch) begin
         rk[0] <= bus.key_in;
      end else if (kload) begin
         rk[kcnt] <= key_next;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         st        <= IDLE;
         blk       <= '0;
         result    <= '0;
         done_flag <= 1'b0;
         kcnt      <= '0;
         rcnt      <= '0;
      end else if (bus.restart) begin
         st        <= IDLE;
         done_flag <= 1'b0;
      end else begin
         unique case (st)
            IDLE, DONE: begin
               if (bus.start) begin
                  blk       <= bus.cipher_text;
                  done_flag <= 1'b0;
                  kcnt      <= 4'd1;
                  st        <= KEYEXP;
               end
            end
            KEYEXP: begin
               if (kcnt == 4'd10) begin
                  st <= INIT;
               end else begin
                  kcnt <= kcnt + 4'd1;
               end
            end
            INIT: begin
               blk  <= blk ^ rk[10];
               rcnt <= 4'd9;
               st   <= ROUND;
            end
            ROUND: begin
               blk  <= imc;
               rcnt <= rcnt - 4'd1;
               if (rcnt == 4'd1) st <= FINAL;
            end
            FINAL: begin
               result    <= final_out;
               done_flag <= 1'b1;
               st        <= DONE;
            end
            default: st <= IDLE;
         endcase
      end
   end

   assign bus.plain_text = result;
   assign bus.done       = done_flag;

endmodule

// File: tb/tb_top_decryption.sv
// Directed bench for top_decryption: FIPS-197 vectors, a forward-cipher
// loopback, restart, ignored start and asynchronous reset sequences.
module tb_top_decryption;

   logic clk;
   logic reset;
   int   n_vec;
   int   n_bad;

   top_decryption_if bus();

   top_decryption dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string        name;
      logic [127:0] key;
      logic [127:0] ct;
      logic [127:0] pt;
   } vec_t;

   localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] LB_PT  = 128'h89c2abb23688ac1c675eb2d4cf2a263e;

   // Forward cipher, used only to produce loopback stimulus.
   function automatic logic [7:0] m_xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = m_xt(x);
      end
      return p;
   endfunction

   function automatic logic [7:0] m_sbox(input logic [7:0] x);
      logic [7:0] r;
      logic [7:0] p;
      logic [7:0] e;
      r = 8'h01;
      p = x;
      e = 8'd254;
      for (int i = 0; i < 8; i++) begin
         if (e[i]) r = m_mul(r, p);
         p = m_mul(p, p);
      end
      return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]}
               ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [127:0] m_encrypt(input logic [127:0] key, input logic [127:0] pt);
      logic [127:0] k;
      logic [127:0] s;
      logic [127:0] t;
      logic [31:0]  w;
      logic [7:0]   rc;
      logic [7:0]   a0, a1, a2, a3;
      k  = key;
      s  = pt ^ k;
      rc = 8'h01;
      for (int rnd = 1; rnd <= 10; rnd++) begin
         w = k[31:0];
         w = {m_sbox(w[23:16]) ^ rc, m_sbox(w[15:8]),
              m_sbox(w[7:0]), m_sbox(w[31:24])};
         k[127:96] = k[127:96] ^ w;
         k[95:64]  = k[95:64]  ^ k[127:96];
         k[63:32]  = k[63:32]  ^ k[95:64];
         k[31:0]   = k[31:0]   ^ k[63:32];
         rc = m_xt(rc);
         for (int i = 0; i < 16; i++) s[127-8*i -: 8] = m_sbox(s[127-8*i -: 8]);
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
               t[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
         s = t;
         if (rnd < 10) begin
            for (int c = 0; c < 4; c++) begin
               a0 = s[127-32*c -: 8];
               a1 = s[119-32*c -: 8];
               a2 = s[111-32*c -: 8];
               a3 = s[103-32*c -: 8];
               s[127-32*c -: 8] = m_xt(a0) ^ m_xt(a1) ^ a1 ^ a2 ^ a3;
               s[119-32*c -: 8] = a0 ^ m_xt(a1) ^ m_xt(a2) ^ a2 ^ a3;
               s[111-32*c -: 8] = a0 ^ a1 ^ m_xt(a2) ^ m_xt(a3) ^ a3;
               s[103-32*c -: 8] = m_xt(a0) ^ a0 ^ a1 ^ a2 ^ m_xt(a3);
            end
         end
         s = s ^ k;
      end
      return s;
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   // Launch at E0, check done stays low through E20 and result after E21.
   task automatic run_op(input string name, input logic [127:0] key,
                         input logic [127:0] ct, input logic [127:0] exp,
                         input bit toggle, input bit chk_drop);
      logic early;
      @(negedge clk);
      bus.key_in      = key;
      bus.cipher_text = ct;
      bus.start       = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      if (chk_drop) check({name, " done drop"}, {127'b0, bus.done}, 128'd0);
      early = 1'b0;
      for (int k = 1; k <= 21; k++) begin
         @(negedge clk);
         if (k < 21 && bus.done) early = 1'b1;
         if (toggle && k >= 11 && k <= 19) begin
            bus.start       = k[0];
            bus.key_in      = B_KEY;
            bus.cipher_text = B_CT;
         end
         if (k == 20) bus.start = 1'b0;
      end
      check({name, " done early"}, {127'b0, early}, 128'd0);
      check({name, " done"}, {127'b0, bus.done}, 128'd1);
      check({name, " plain"}, bus.plain_text, exp);
   endtask

   vec_t vecs [3];

   initial begin
      logic early;
      n_vec = 0;
      n_bad = 0;

      vecs[0] = '{"c1", C1_KEY, C1_CT, C1_PT};
      vecs[1] = '{"appb", B_KEY, B_CT, B_PT};
      vecs[2] = '{"loop", C1_KEY, m_encrypt(C1_KEY, LB_PT), LB_PT};

      reset           = 1'b1;
      bus.start       = 1'b0;
      bus.restart     = 1'b0;
      bus.key_in      = '0;
      bus.cipher_text = '0;
      #12;
      check("rst done", {127'b0, bus.done}, 128'd0);
      check("rst plain", bus.plain_text, 128'd0);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 3; i++) begin
         run_op(vecs[i].name, vecs[i].key, vecs[i].ct, vecs[i].pt, 1'b0, i > 0);
      end

      // Restart at E8 with inputs switched to the Appendix B vector.
      @(negedge clk);
      bus.key_in      = C1_KEY;
      bus.cipher_text = C1_CT;
      bus.start       = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (7) @(negedge clk);
      bus.restart     = 1'b1;
      bus.key_in      = B_KEY;
      bus.cipher_text = B_CT;
      @(negedge clk);
      bus.restart = 1'b0;
      check("rs done", {127'b0, bus.done}, 128'd0);
      check("rs plain", bus.plain_text, LB_PT);
      early = 1'b0;
      repeat (25) begin
         @(negedge clk);
         if (bus.done) early = 1'b1;
      end
      check("rs idle", {127'b0, early}, 128'd0);
      check("rs plain hold", bus.plain_text, LB_PT);
      run_op("relaunch", B_KEY, B_CT, B_PT, 1'b0, 1'b0);

      // Start toggled and inputs changed mid-run must be ignored.
      run_op("toggle", C1_KEY, C1_CT, C1_PT, 1'b1, 1'b1);

      // Start and restart together in DONE: restart wins.
      bus.start   = 1'b1;
      bus.restart = 1'b1;
      @(negedge clk);
      bus.start   = 1'b0;
      bus.restart = 1'b0;
      check("sr done", {127'b0, bus.done}, 128'd0);
      check("sr plain", bus.plain_text, C1_PT);
      early = 1'b0;
      repeat (25) begin
         @(negedge clk);
         if (bus.done) early = 1'b1;
      end
      check("sr no launch", {127'b0, early}, 128'd0);

      // Asynchronous reset between edges during round processing.
      @(negedge clk);
      bus.key_in      = C1_KEY;
      bus.cipher_text = C1_CT;
      bus.start       = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (14) @(negedge clk);
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      check("ar done", {127'b0, bus.done}, 128'd0);
      check("ar plain", bus.plain_text, 128'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      early = 1'b0;
      repeat (30) begin
         @(negedge clk);
         if (bus.done) early = 1'b1;
      end
      check("ar quiet", {127'b0, early}, 128'd0);
      check("ar plain hold", bus.plain_text, 128'd0);
      run_op("post rst", C1_KEY, C1_CT, C1_PT, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/top_decryption.md
# top_decryption

- Iterative AES-128 inverse cipher (FIPS-197): decrypts one 128-bit block with a 128-bit key, one round per clock.
- Receive-side counterpart of `top_encryption`. It uses the same start/restart control style, so a `top_encryption` ciphertext fed in with the same key yields the original plaintext.
- On `start`, expands the key into an internal round-key store, then runs the inverse rounds from round key 10 down to round key 0.
- Presents the plaintext with a level `done` flag.

## Interface
- No parameters; block size and key size fixed at 128 bits.
- `clk` — input, 1 bit — single clock; all state updates on the rising edge.
- `reset` — input, 1 bit — one clock; reset is asynchronous and active-high.
- `start` — input, 1 bit — launch request; sampled only in IDLE or DONE.
- `restart` — input, 1 bit — synchronous abort to IDLE; has priority over `start`.
- `key_in` — input, 128 bits — cipher key; byte 0 = bits [127:120].
- `cipher_text` — input, 128 bits — ciphertext block; FIPS-197 byte/column order, byte 0 = [127:120].
- `plain_text` — output, 128 bits — registered result; valid while `done`=1.
- `done` — output, 1 bit — registered; high in the DONE state.

## Operation
- FSM states: IDLE, KEYEXP, INIT, ROUND, FINAL, DONE.
- IDLE/DONE with `start`=1 and `restart`=0:
  - latch `key_in` into rk[0] and `cipher_text` into the state register;
  - clear `done`; go to KEYEXP with key counter = 1.
- KEYEXP:
  - one round key per cycle: rk[i] = f(rk[i-1], Rcon[i]);
  - f = RotWord, forward SubWord and Rcon on the last word, then XOR chain over the 4 words;
  - Rcon = 01,02,04,08,10,20,40,80,1b,36.
  - After rk[10] is written, go to INIT.
- INIT: state ← state ^ rk[10]; round counter r ← 9; go to ROUND.
- ROUND:
  - state ← InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk[r]);
  - r decrements; when r was 1, go to FINAL.
- FINAL: `plain_text` ← InvSubBytes(InvShiftRows(state)) ^ rk[0]; `done` ← 1; go to DONE.
- DONE:
  - hold `plain_text` and `done` until `start` or `restart`;
  - `start` launches a new operation as in IDLE.
- Datapath resources:
  - 16 inverse S-boxes for the data path; 4 forward S-boxes for key expansion.
  - Round-key store: 11×128 flops.
  - InvMixColumns uses GF(2^8) multiply by 09/0b/0d/0e, reduction polynomial 0x11b.
- `start` in KEYEXP/INIT/ROUND/FINAL is ignored.
- Inputs are not re-sampled after launch; changes to `key_in`/`cipher_text` mid-operation have no effect.
- `restart`=1 in any state:
  - next state IDLE; `done` ← 0; `plain_text` holds its last value;
  - the round-key store and counters need not clear.
- `restart` and `start` asserted in the same cycle: restart wins; no launch.

## Timing
- Reset (async, active-high): FSM = IDLE, `done`=0, `plain_text`=0, state register = 0, counters = 0. Key store contents don't care.
- Label the rising edge that samples `start` as E0:
  - E1..E10: rk[1]..rk[10] written;
  - E11: INIT;
  - E12..E20: nine full inverse rounds;
  - E21: FINAL; `plain_text` and `done` update together.
- Latency: `done` rises 21 cycles after the launching edge.
- Throughput: one block per 22 cycles when `start` is held high (DONE state, then relaunch).
- Back-to-back operation: in DONE with `start`=1, `done` drops on the next edge and rises again 21 cycles later.
- Reset asserted mid-operation: immediate return to reset values; no `done` pulse is produced.
- No combinational path from inputs to outputs.

## Test plan
- FIPS-197 C.1:
  - stimulus: key 000102030405060708090a0b0c0d0e0f, cipher 69c4e0d86a7b0430d8cdb78070b4c55a, `start` pulse at E0;
  - required: `done`=1 after E21, `plain_text`=00112233445566778899aabbccddeeff, `done` low through E20.
- FIPS-197 Appendix B:
  - stimulus: key 2b7e151628aed2a6abf7158809cf4f3c, cipher 3925841d02dc09fbdc118597196a0b32;
  - required: `plain_text`=3243f6a8885a308d313198a2e0370734.
- Loopback:
  - stimulus: `top_encryption` output for key 000102030405060708090A0B0C0D0E0F, plaintext 89c2abb23688ac1c675eb2d4cf2a263e, fed to this block with the same key;
  - required: `plain_text`=89c2abb23688ac1c675eb2d4cf2a263e.
- Restart mid-run:
  - stimulus: launch C.1, assert `restart` at E8, change inputs to the Appendix B vector;
  - required: FSM in IDLE, `done`=0, `plain_text` unchanged.
  - Then relaunch: Appendix B result after E21 of the new run.
- Ignored/simultaneous control:
  - stimulus: `start` toggled during ROUND, then `start`+`restart` asserted together in DONE;
  - required: first result unaffected, then DONE→IDLE with no launch and `done`=0.
- Async reset:
  - stimulus: `reset` asserted between clock edges at E15;
  - required: `done`=0 and `plain_text`=0 immediately; no `done` for 30 cycles; a fresh launch gives the correct C.1 result.
